// File: rtl/moore_mod_counter_detector.sv
// Programmable-range Moore event counter: counts x_in cycles through 0..last_r,
// up or down, wrapping or saturating, with registered match/wrap/saturation flags.
module moore_mod_counter_detector #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_in,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] cfg_last,
  input  logic [WIDTH-1:0] cfg_match,
  input  logic             cfg_sat,
  input  logic             cfg_down,
  output logic             y_out,
  output logic [WIDTH-1:0] state_out,
  output logic             wrap_out,
  output logic             sat_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1'b1);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] last_r;
  logic [WIDTH-1:0] match_r;
  logic             sat_r;
  logic             down_r;
  logic             wrap_r;
  logic             y_r;
  logic             sat_flag_r;

  logic [WIDTH-1:0] state_nx;
  logic [WIDTH-1:0] last_nx;
  logic [WIDTH-1:0] match_nx;
  logic             sat_nx;
  logic             down_nx;
  logic             wrap_nx;
  logic             y_nx;
  logic             sat_flag_nx;

  // Next count and configuration with priority clr > load > x_in.
  always_comb begin
    state_nx = state;
    last_nx  = last_r;
    match_nx = match_r;
    sat_nx   = sat_r;
    down_nx  = down_r;
    wrap_nx  = 1'b0;
    if (clr) begin
      state_nx = '0;
    end else if (load) begin
      last_nx  = cfg_last;
      match_nx = cfg_match;
      sat_nx   = cfg_sat;
      down_nx  = cfg_down;
      state_nx = cfg_down ? cfg_last : '0;
    end else if (x_in) begin
      if (!down_r) begin
        if (state < last_r) begin
          state_nx = state + ONE;
        end else if (!sat_r) begin
          state_nx = '0;
          wrap_nx  = 1'b1;
        end else begin
          state_nx = state;
        end
      end else begin
        if (state != '0) begin
          state_nx = state - ONE;
        end else if (!sat_r) begin
          state_nx = last_r;
          wrap_nx  = 1'b1;
        end else begin
          state_nx = state;
        end
      end
    end else begin
      state_nx = state;
    end
    // Flags are decoded from next-state values so they appear with the new count.
    y_nx        = (state_nx == match_nx);
    sat_flag_nx = sat_nx && (down_nx ? (state_nx == '0) : (state_nx == last_nx));
  end

  // State, configuration and output flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= '0;
      last_r     <= '1;
      match_r    <= '1;
      sat_r      <= 1'b0;
      down_r     <= 1'b0;
      wrap_r     <= 1'b0;
      y_r        <= 1'b0;
      sat_flag_r <= 1'b0;
    end else begin
      state      <= state_nx;
      last_r     <= last_nx;
      match_r    <= match_nx;
      sat_r      <= sat_nx;
      down_r     <= down_nx;
      wrap_r     <= wrap_nx;
      y_r        <= y_nx;
      sat_flag_r <= sat_flag_nx;
    end
  end

  assign state_out = state;
  assign y_out     = y_r;
  assign wrap_out  = wrap_r;
  assign sat_out   = sat_flag_r;

endmodule

// File: doc/moore_mod_counter_detector.md
# moore_mod_counter_detector

Parametrised Moore event counter/detector and the successor to the fixed 2-bit, 4-state ones-counting detector. It counts cycles with `x_in` high, in WIDTH bits, through states 0..M, where M is a runtime-programmable last state. The count can run up or down and can wrap or saturate. A Moore output asserts while the count equals a programmable match value. It sits between an event source (pulse or strobe logic) and control logic that needs "N events seen" or "terminal count" indications.

## Interface
- `WIDTH`, default 4: counter/state width in bits; must be ≥ 1.
- `clk`, input, 1: rising-edge clock; the only clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `x_in`, input, 1: count-event qualifier, sampled on each rising `clk`.
- `clr`, input, 1: synchronous clear of the count; configuration is kept.
- `load`, input, 1: synchronous load of the configuration inputs.
- `cfg_last`, input, WIDTH: last state M; the count range is 0..M.
- `cfg_match`, input, WIDTH: match value for `y_out`.
- `cfg_sat`, input, 1: 1 = saturate at the range end, 0 = wrap.
- `cfg_down`, input, 1: 1 = count down, 0 = count up.
- `y_out`, output, 1: Moore output, high when state == match_r.
- `state_out`, output, WIDTH: current count.
- `wrap_out`, output, 1: one-cycle registered wrap indication.
- `sat_out`, output, 1: high while saturated at the range end.

## Operation
- Internal registers: `state`, `last_r`, `match_r`, `sat_r`, `down_r`, `wrap_r`.
- Reset values (rst = 0, asynchronous):
  - `state` = 0.
  - `last_r` = all ones; `match_r` = all ones.
  - `sat_r` = 0; `down_r` = 0; `wrap_r` = 0.
  - Resulting outputs: `state_out` = 0, `y_out` = 0 (0 == all ones is false for WIDTH ≥ 1), `wrap_out` = 0, `sat_out` = 0.
- Backward compatibility: with WIDTH = 2 and no load, the block behaves exactly as the 4-state detector, with `y_out` high in state 3.
- Priority on each rising `clk` (rst = 1): clr > load > x_in.
  - clr = 1: state ← 0; wrap_r ← 0; configuration is unchanged.
  - load = 1 (clr = 0):
    - last_r ← cfg_last; match_r ← cfg_match; sat_r ← cfg_sat; down_r ← cfg_down.
    - state ← 0 if cfg_down = 0, else state ← cfg_last.
    - wrap_r ← 0.
  - x_in = 1, up mode:
    - state < last_r: state + 1.
    - state == last_r, wrap mode: state ← 0, wrap_r ← 1.
    - state == last_r, saturate mode: hold.
  - x_in = 1, down mode:
    - state > 0: state − 1.
    - state == 0, wrap mode: state ← last_r, wrap_r ← 1.
    - state == 0, saturate mode: hold.
  - x_in = 0: state holds; wrap_r ← 0.
- wrap_r is 0 on every edge that does not produce a wrap. `wrap_out` = wrap_r.
- `y_out` = (state == match_r). It is decoded from registers only, with no combinational path from `x_in`.
- `sat_out` = sat_r AND (state == last_r in up mode, or state == 0 in down mode). It is decoded from registers only.
- If match_r > last_r, `y_out` never asserts. This is legal and not flagged.
- last_r = 0:
  - State stays 0.
  - Wrap mode: every x_in = 1 edge sets wrap_out.
  - Saturate mode: sat_out is constantly 1.
- Arithmetic is unsigned, WIDTH bits, with no carry out. State can never exceed last_r, because load re-initialises the state.

## Timing
- Latency: an x_in sampled at edge k is reflected on `state_out`, `y_out` and `sat_out` immediately after edge k.
- `wrap_out` is high for exactly the one cycle following the wrapping edge, concurrent with the wrapped state value.
- Back-to-back wraps (last_r = 0 with x_in held high) keep `wrap_out` high continuously.
- Simultaneous clr and load: clr wins and the configuration is not loaded.
- Simultaneous load and x_in: the load wins and the count event is dropped.
- Reset asserted mid-count: all registers return to their reset values asynchronously, without waiting for a clock edge. Counting resumes on the first rising `clk` after rst returns high.

## Test plan
- Reset defaults, WIDTH = 2, four x_in pulses:
  - State sequence 1, 2, 3, 0.
  - `y_out` = 1 only at state 3.
  - `wrap_out` = 1 for one cycle with state 0.
- WIDTH = 4, load with cfg_last = 9, cfg_match = 5, up, wrap; x_in held high for 12 cycles:
  - State runs 1..9, then 0, 1, 2.
  - `y_out` is high for one cycle at state 5.
  - `wrap_out` pulses once.
- Load with cfg_last = 6, cfg_sat = 1, cfg_down = 1:
  - State starts at 6.
  - After 8 x_in pulses: state = 0 and `sat_out` = 1.
  - `wrap_out` is never asserted.
- State = 4, then clr and load asserted together with x_in = 1 and a different cfg:
  - Next state = 0.
  - Old configuration retained (check via the `y_out` match behaviour).
- rst pulled low asynchronously between clock edges at state 7:
  - Outputs go to 0/0/0 immediately, without a clock edge.
  - The first x_in after release gives state 1.
- last_r = 0, wrap mode, x_in high for 3 cycles:
  - State stays 0.
  - `wrap_out` is high for 3 consecutive cycles.
  - `y_out` = 1 if match_r = 0.
